// File: rtl/wb_merge_if.sv
// Write-back merge bundle: ALU write, load issue, load response and register file write port.
// The core side uses master. wb_merge uses slave.
interface wb_merge_if;
  logic        alu_we;
  logic [4:0]  alu_wn;
  logic [31:0] alu_wd;
  logic        ld_issue;
  logic [4:0]  ld_issue_wn;
  // Response handshake: a beat transfers on a posedge where ld_rsp_valid && ld_rsp_ready.
  // The producer holds wn/data stable while valid is high. Ready never depends on valid.
  logic        ld_rsp_valid;
  logic [4:0]  ld_rsp_wn;
  logic [31:0] ld_rsp_data;
  logic        ld_rsp_ready;
  logic        RegWrite;
  logic [4:0]  WN;
  logic [31:0] WD;
  logic [31:0] busy;
  logic        hazard_err;

  modport master (
    output alu_we, alu_wn, alu_wd, ld_issue, ld_issue_wn,
           ld_rsp_valid, ld_rsp_wn, ld_rsp_data,
    input  ld_rsp_ready, RegWrite, WN, WD, busy, hazard_err
  );

  modport slave (
    input  alu_we, alu_wn, alu_wd, ld_issue, ld_issue_wn,
           ld_rsp_valid, ld_rsp_wn, ld_rsp_data,
    output ld_rsp_ready, RegWrite, WN, WD, busy, hazard_err
  );
endinterface

// File: rtl/wb_merge.sv
// Merges same-cycle ALU writes with late load responses onto one register file write port.
// Define WB_MERGE_BYPASS_EN to let a response go straight to an idle port when the queue is empty.
module wb_merge #(
  parameter int coreID   = 0,
  parameter int LQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  wb_merge_if.slave                 bus,
  output logic [$clog2(LQ_DEPTH):0] lq_count
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    wn_mem_q   [LQ_DEPTH];
  logic [31:0]   data_mem_q [LQ_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic          haz_q, haz_d;

  logic          alu_eff, lq_empty, accept, push, pop, byp;
  logic          ld_wr;
  logic [4:0]    ld_wr_wn;
  logic [31:0]   ld_wr_data;
  logic          unused_core_id;

  assign unused_core_id = ^32'(coreID);

  always_comb begin
    alu_eff          = bus.alu_we && (bus.alu_wn != 5'd0);
    lq_empty         = (count_q == '0);
    bus.ld_rsp_ready = !reset && (count_q < CW'(LQ_DEPTH));
    byp              = 1'b0;
`ifdef WB_MERGE_BYPASS_EN
    byp              = !reset && !alu_eff && lq_empty && bus.ld_rsp_valid;
`endif
    pop              = !reset && !alu_eff && !lq_empty;
    accept           = bus.ld_rsp_valid && bus.ld_rsp_ready;
    push             = accept && !byp;
  end

  // Load-path write: queue head first, otherwise a bypassed response. r0 targets are consumed silently.
  always_comb begin
    ld_wr      = 1'b0;
    ld_wr_wn   = 5'd0;
    ld_wr_data = 32'd0;
    if (pop) begin
      ld_wr_wn   = wn_mem_q[rd_ptr_q];
      ld_wr_data = data_mem_q[rd_ptr_q];
      ld_wr      = (ld_wr_wn != 5'd0);
    end else if (byp) begin
      ld_wr_wn   = bus.ld_rsp_wn;
      ld_wr_data = bus.ld_rsp_data;
      ld_wr      = (ld_wr_wn != 5'd0);
    end
  end

  always_comb begin
    bus.RegWrite = 1'b0;
    bus.WN       = 5'd0;
    bus.WD       = 32'd0;
    if (alu_eff && !reset) begin
      bus.RegWrite = 1'b1;
      bus.WN       = bus.alu_wn;
      bus.WD       = bus.alu_wd;
    end else if (ld_wr) begin
      bus.RegWrite = 1'b1;
      bus.WN       = ld_wr_wn;
      bus.WD       = ld_wr_data;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);

    // Set after clear so a same-cycle reissue keeps the register busy.
    busy_d = busy_q;
    if (ld_wr) busy_d[ld_wr_wn] = 1'b0;
    if (bus.ld_issue && (bus.ld_issue_wn != 5'd0)) busy_d[bus.ld_issue_wn] = 1'b1;
    busy_d[0] = 1'b0;

    haz_d = haz_q;
    if (alu_eff && busy_q[bus.alu_wn]) haz_d = 1'b1;
    if (bus.ld_issue && (bus.ld_issue_wn != 5'd0) && busy_q[bus.ld_issue_wn]) haz_d = 1'b1;
    if (ld_wr && !busy_q[ld_wr_wn]) haz_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      haz_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      haz_q    <= haz_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      wn_mem_q[wr_ptr_q]   <= bus.ld_rsp_wn;
      data_mem_q[wr_ptr_q] <= bus.ld_rsp_data;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.hazard_err = haz_q;
  assign lq_count       = count_q;
endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: queue-based reference model checked every cycle plus directed literal checks.
// Builds with or without WB_MERGE_BYPASS_EN.
module tb_wb_merge;
  localparam int LQ_DEPTH = 4;
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [CW-1:0] lq_count;
  int            n_pass = 0;
  int            n_total = 0;
  int            acc;

  logic [36:0]   exp_q[$];
  logic [31:0]   m_busy;
  logic          m_haz;
  bit            model_on = 0;

  wb_merge_if bus();

  wb_merge #(.coreID(0), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .lq_count (lq_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    else n_pass++;
  endtask

  task automatic idle();
    bus.alu_we       = 1'b0;
    bus.alu_wn       = 5'd0;
    bus.alu_wd       = 32'd0;
    bus.ld_issue     = 1'b0;
    bus.ld_issue_wn  = 5'd0;
    bus.ld_rsp_valid = 1'b0;
    bus.ld_rsp_wn    = 5'd0;
    bus.ld_rsp_data  = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Reference model: pending responses in exp_q, busy as a bit vector, sticky hazard flag.
  always @(negedge clk) begin
    logic        alu_eff, byp, e_we, ld_wr, e_ready;
    logic [4:0]  e_wn, ld_wn;
    logic [31:0] e_wd;
    logic [36:0] head;
    if (!model_on) begin
      if (reset === 1'b1) begin
        model_on = 1;
        exp_q.delete();
        m_busy = '0;
        m_haz  = 1'b0;
      end
    end else begin
      check("m_lq_count", 32'(lq_count), 32'(exp_q.size()));
      check("m_busy", bus.busy, m_busy);
      check("m_hazard", 32'(bus.hazard_err), 32'(m_haz));
      if (reset) begin
        check("m_rst_regwrite", 32'(bus.RegWrite), 32'd0);
        check("m_rst_ready", 32'(bus.ld_rsp_ready), 32'd0);
        exp_q.delete();
        m_busy = '0;
        m_haz  = 1'b0;
      end else begin
        alu_eff = bus.alu_we && (bus.alu_wn != 5'd0);
        e_ready = (exp_q.size() < LQ_DEPTH);
        e_we = 1'b0; e_wn = 5'd0; e_wd = 32'd0;
        ld_wr = 1'b0; ld_wn = 5'd0; byp = 1'b0;
        if (alu_eff) begin
          e_we = 1'b1; e_wn = bus.alu_wn; e_wd = bus.alu_wd;
        end else if (exp_q.size() != 0) begin
          head  = exp_q.pop_front();
          ld_wn = head[36:32];
          if (ld_wn != 5'd0) begin
            e_we = 1'b1; e_wn = ld_wn; e_wd = head[31:0]; ld_wr = 1'b1;
          end
        end
`ifdef WB_MERGE_BYPASS_EN
        else if (bus.ld_rsp_valid) begin
          byp   = 1'b1;
          ld_wn = bus.ld_rsp_wn;
          if (ld_wn != 5'd0) begin
            e_we = 1'b1; e_wn = ld_wn; e_wd = bus.ld_rsp_data; ld_wr = 1'b1;
          end
        end
`endif
        check("m_ready", 32'(bus.ld_rsp_ready), 32'(e_ready));
        check("m_regwrite", 32'(bus.RegWrite), 32'(e_we));
        check("m_wn", 32'(bus.WN), 32'(e_wn));
        check("m_wd", bus.WD, e_wd);
        if (bus.ld_rsp_valid && e_ready && !byp) exp_q.push_back({bus.ld_rsp_wn, bus.ld_rsp_data});
        if (alu_eff && m_busy[bus.alu_wn]) m_haz = 1'b1;
        if (bus.ld_issue && bus.ld_issue_wn != 5'd0 && m_busy[bus.ld_issue_wn]) m_haz = 1'b1;
        if (ld_wr && !m_busy[ld_wn]) m_haz = 1'b1;
        if (ld_wr) m_busy[ld_wn] = 1'b0;
        if (bus.ld_issue && bus.ld_issue_wn != 5'd0) m_busy[bus.ld_issue_wn] = 1'b1;
      end
    end
  end

  initial begin
    // Reset held with traffic present
    idle();
    reset = 1'b1;
    bus.alu_we = 1'b1; bus.alu_wn = 5'd2; bus.alu_wd = 32'h55;
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_wn = 5'd3; bus.ld_rsp_data = 32'h1;
    sample();
    check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    check("rst_ready", 32'(bus.ld_rsp_ready), 32'd0);
    sample();
    check("rst_lq_count", 32'(lq_count), 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_regwrite2", 32'(bus.RegWrite), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle();
    sample();
    check("post_rst_ready", 32'(bus.ld_rsp_ready), 32'd1);
    check("post_rst_hazard", 32'(bus.hazard_err), 32'd0);

    // Load to r5, response the next cycle with ALU idle
    next_cycle();
    bus.ld_issue = 1'b1; bus.ld_issue_wn = 5'd5;
    next_cycle();
    idle();
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_wn = 5'd5; bus.ld_rsp_data = 32'hDEADBEEF;
    sample();
    check("byp_busy5_set", 32'(bus.busy[5]), 32'd1);
`ifdef WB_MERGE_BYPASS_EN
    check("byp_regwrite", 32'(bus.RegWrite), 32'd1);
    check("byp_wn", 32'(bus.WN), 32'd5);
    check("byp_wd", bus.WD, 32'hDEADBEEF);
    next_cycle();
    idle();
    sample();
    check("byp_busy5_clr", 32'(bus.busy[5]), 32'd0);
    check("byp_lq_count", 32'(lq_count), 32'd0);
`else
    check("nobyp_regwrite0", 32'(bus.RegWrite), 32'd0);
    next_cycle();
    idle();
    sample();
    check("nobyp_regwrite1", 32'(bus.RegWrite), 32'd1);
    check("nobyp_wn", 32'(bus.WN), 32'd5);
    check("nobyp_wd", bus.WD, 32'hDEADBEEF);
    check("nobyp_lq_count", 32'(lq_count), 32'd1);
    next_cycle();
    sample();
    check("nobyp_busy5_clr", 32'(bus.busy[5]), 32'd0);
`endif

    // Backpressure: ALU busy for 8 cycles while 6 responses are offered
    next_cycle();
    idle();
    for (int i = 0; i < 6; i++) begin
      bus.ld_issue = 1'b1; bus.ld_issue_wn = 5'(10 + i);
      next_cycle();
    end
    idle();
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.alu_we = 1'b1; bus.alu_wn = 5'(i + 1); bus.alu_wd = 32'h100 + 32'(i);
      bus.ld_rsp_valid = (acc < 6);
      bus.ld_rsp_wn    = 5'(10 + acc);
      bus.ld_rsp_data  = 32'h1000 + 32'(10 + acc);
      sample();
      check("bp_alu_we", 32'(bus.RegWrite), 32'd1);
      check("bp_alu_wn", 32'(bus.WN), 32'(i + 1));
      check("bp_alu_wd", bus.WD, 32'h100 + 32'(i));
      check("bp_ready", 32'(bus.ld_rsp_ready), 32'(i < 4));
      if (bus.ld_rsp_valid && bus.ld_rsp_ready) acc++;
      next_cycle();
    end
    check("bp_accepted", 32'(acc), 32'd4);
    idle();
    for (int j = 0; j < 6; j++) begin
      bus.ld_rsp_valid = (acc < 6);
      bus.ld_rsp_wn    = 5'(10 + acc);
      bus.ld_rsp_data  = 32'h1000 + 32'(10 + acc);
      sample();
      check("drain_we", 32'(bus.RegWrite), 32'd1);
      check("drain_wn", 32'(bus.WN), 32'(10 + j));
      check("drain_wd", bus.WD, 32'h1000 + 32'(10 + j));
      if (bus.ld_rsp_valid && bus.ld_rsp_ready) acc++;
      next_cycle();
    end
    idle();
    sample();
    check("drain_lq_empty", 32'(lq_count), 32'd0);
    check("drain_busy", bus.busy, 32'd0);
    check("drain_hazard", 32'(bus.hazard_err), 32'd0);

    // Collision: ALU r3=7 and response r7=9 together
    next_cycle();
    bus.ld_issue = 1'b1; bus.ld_issue_wn = 5'd7;
    next_cycle();
    idle();
    bus.alu_we = 1'b1; bus.alu_wn = 5'd3; bus.alu_wd = 32'd7;
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_wn = 5'd7; bus.ld_rsp_data = 32'd9;
    sample();
    check("col_wn_alu", 32'(bus.WN), 32'd3);
    check("col_wd_alu", bus.WD, 32'd7);
    next_cycle();
    idle();
    sample();
    check("col_we_ld", 32'(bus.RegWrite), 32'd1);
    check("col_wn_ld", 32'(bus.WN), 32'd7);
    check("col_wd_ld", bus.WD, 32'd9);

    // Response to non-busy r4 is written and flags a hazard
    next_cycle();
    bus.ld_rsp_valid = 1'b1; bus.ld_rsp_wn = 5'd4; bus.ld_rsp_data = 32'h44;
    sample();
    check("hz_r4_pre", 32'(bus.hazard_err), 32'd0);
    next_cycle();
    idle();
    sample();
`ifndef WB_MERGE_BYPASS_EN
    check("hz_r4_we", 32'(bus.RegWrite), 32'd1);
    check("hz_r4_wn", 32'(bus.WN), 32'd4);
`endif
    next_cycle();
    sample();
    check("hz_r4_set", 32'(bus.hazard_err), 32'd1);

    next_cycle();
    reset = 1'b1;
    sample();
    next_cycle();
    reset = 1'b0;
    sample();
    check("hz_cleared_by_rst", 32'(bus.hazard_err), 32'd0);

    // Double issue to r9, then issue to r0
    next_cycle();
    bus.ld_issue = 1'b1; bus.ld_issue_wn = 5'd9;
    next_cycle();
    sample();
    check("hz_r9_first", 32'(bus.hazard_err), 32'd0);
    next_cycle();
    idle();
    sample();
    check("hz_r9_set", 32'(bus.hazard_err), 32'd1);
    check("hz_r9_busy", bus.busy, 32'h0000_0200);
    next_cycle();
    bus.ld_issue = 1'b1; bus.ld_issue_wn = 5'd0;
    next_cycle();
    idle();
    sample();
    check("hz_r0_busy", 32'(bus.busy[0]), 32'd0);
    check("hz_sticky", 32'(bus.hazard_err), 32'd1);

    // Reset with three entries queued
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      bus.ld_issue = 1'b1; bus.ld_issue_wn = 5'(20 + i);
      next_cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.alu_we = 1'b1; bus.alu_wn = 5'd1; bus.alu_wd = 32'(i);
      bus.ld_rsp_valid = 1'b1; bus.ld_rsp_wn = 5'(20 + i); bus.ld_rsp_data = 32'h2000 + 32'(i);
      next_cycle();
    end
    idle();
    reset = 1'b1;
    sample();
    check("mid_rst_lq3", 32'(lq_count), 32'd3);
    check("mid_rst_we", 32'(bus.RegWrite), 32'd0);
    next_cycle();
    reset = 1'b0;
    sample();
    check("mid_rst_lq0", 32'(lq_count), 32'd0);
    check("mid_rst_busy", bus.busy, 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("mid_rst_no_stale", 32'(bus.RegWrite), 32'd0);
      next_cycle();
      sample();
    end

    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
